// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: a preamble of PRE_LEN ones, then NBYTES frames of
// [8 data bits MSB-first, 0, 1] read from a synchronous-read byte memory.
module serial_frame_tx #(
    parameter int NBYTES  = 721,
    parameter int PRE_LEN = 10,
    parameter int GAP_LEN = 10,
    parameter int AW      = 10
) (
    input  logic          CLK_30MHZ,
    input  logic          RSTN,
    input  logic          START,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [7:0]    MEM_DATA,
    output logic          DOUT,
    output logic          BUSY,
    output logic          DONE
);

    localparam int MAX_LEN = (PRE_LEN > GAP_LEN) ? PRE_LEN : GAP_LEN;
    localparam int CW      = (MAX_LEN > 15) ? $clog2(MAX_LEN + 1) : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_STOP0,
        S_STOP1,
        S_GAP
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [3:0]      bit_cnt_reg;
    logic [AW-1:0]   byte_cnt_reg;
    logic [7:0]      shreg_reg;
    logic [AW-1:0]   mem_addr_reg;
    logic            dout_reg;
    logic            busy_reg;
    logic            done_reg;

    assign MEM_ADDR = mem_addr_reg;
    assign DOUT     = dout_reg;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;

    // DOUT is registered, so the MSB of a freshly read byte goes straight to
    // the line and the shift register keeps only the bits still to be sent.
    always_ff @(posedge CLK_30MHZ) begin
        if (!RSTN) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            shreg_reg    <= '0;
            mem_addr_reg <= '0;
            dout_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg     <= 1'b0;
                    mem_addr_reg <= '0;
                    byte_cnt_reg <= '0;
                    cnt_reg      <= '0;
                    if (START) begin
                        state_reg <= S_PRE;
                        dout_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                    end else begin
                        dout_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (cnt_reg == CW'(PRE_LEN - 1)) begin
                        cnt_reg     <= '0;
                        bit_cnt_reg <= '0;
                        shreg_reg   <= {MEM_DATA[6:0], 1'b0};
                        dout_reg    <= MEM_DATA[7];
                        state_reg   <= S_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_DATA: begin
                    // Prefetch the next byte early; the load happens nine cycles later.
                    if (bit_cnt_reg == 4'd0 && byte_cnt_reg != AW'(NBYTES - 1)) begin
                        mem_addr_reg <= byte_cnt_reg + AW'(1);
                    end
                    if (bit_cnt_reg == 4'd7) begin
                        bit_cnt_reg <= '0;
                        dout_reg    <= 1'b0;
                        state_reg   <= S_STOP0;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        dout_reg    <= shreg_reg[7];
                        shreg_reg   <= {shreg_reg[6:0], 1'b0};
                    end
                end
                S_STOP0: begin
                    dout_reg  <= 1'b1;
                    state_reg <= S_STOP1;
                end
                S_STOP1: begin
                    if (byte_cnt_reg < AW'(NBYTES - 1)) begin
                        byte_cnt_reg <= byte_cnt_reg + AW'(1);
                        shreg_reg    <= {MEM_DATA[6:0], 1'b0};
                        dout_reg     <= MEM_DATA[7];
                        state_reg    <= S_DATA;
                    end else begin
                        byte_cnt_reg <= '0;
                        mem_addr_reg <= '0;
                        cnt_reg      <= '0;
                        dout_reg     <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= S_GAP;
                    end
                end
                S_GAP: begin
                    done_reg <= 1'b0;
                    if (cnt_reg == CW'(GAP_LEN - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    dout_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench: full-size block with counting and random images, ignored
// START pulses, back-to-back blocks, mid-block reset, and a two-byte instance.
module tb_serial_frame_tx;

    localparam int NB  = 721;
    localparam int PRE = 10;
    localparam int GAP = 10;
    localparam int BLK = PRE + 10 * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a, start_a, dout_a, busy_a, done_a;
    logic [9:0] mem_addr_a;
    logic [7:0] mem_data_a;
    logic       rstn_b, start_b, dout_b, busy_b, done_b;
    logic [1:0] mem_addr_b;
    logic [7:0] mem_data_b;

    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:3];
    logic [9:0] fw    [0:3];

    int num_checks = 0;
    int num_errors = 0;

    serial_frame_tx #(.NBYTES(NB), .PRE_LEN(PRE), .GAP_LEN(GAP), .AW(10)) u_dut (
        .CLK_30MHZ(clk), .RSTN(rstn_a), .START(start_a), .MEM_ADDR(mem_addr_a),
        .MEM_DATA(mem_data_a), .DOUT(dout_a), .BUSY(busy_a), .DONE(done_a)
    );

    serial_frame_tx #(.NBYTES(2), .PRE_LEN(10), .GAP_LEN(10), .AW(2)) u_dut_small (
        .CLK_30MHZ(clk), .RSTN(rstn_b), .START(start_b), .MEM_ADDR(mem_addr_b),
        .MEM_DATA(mem_data_b), .DOUT(dout_b), .BUSY(busy_b), .DONE(done_b)
    );

    always @(posedge clk) begin
        mem_data_a <= mem_a[mem_addr_a];
        mem_data_b <= mem_b[mem_addr_b];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input int idx);
        int j;
        logic [7:0] d;
        if (idx < PRE) return 1'b1;
        if (idx >= BLK) return 1'b0;
        j = idx - PRE;
        d = mem_a[j / 10];
        case (j % 10)
            8:       return 1'b0;
            9:       return 1'b1;
            default: return d[7 - (j % 10)];
        endcase
    endfunction

    // START asserted in IDLE must raise BUSY on the very next cycle.
    task automatic start_a_req(input string name, input bit hold);
        start_a = 1'b1;
        @(negedge clk);
        check({name, "_start_lat"}, busy_a, 1);
        if (!hold) start_a = 1'b0;
    endtask

    // mode 0: START low; 1: stray START pulses in PRE, DATA and GAP;
    // 2: START held high (back-to-back); 3: START held, dropped during block.
    task automatic observe_block(input int mode, input string name);
        int w, idx, bit_errs, done_seen, dout_hi, low_len, j, f, b;
        w = 0;
        while (busy_a !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({name, "_busy_seen"}, busy_a, 1);
        idx = 0; bit_errs = 0; done_seen = 0;
        while (busy_a === 1'b1 && idx < BLK + 5) begin
            if (dout_a !== exp_bit(idx)) bit_errs++;
            if (done_a !== 1'b0) done_seen++;
            if (idx >= PRE && idx < BLK) begin
                j = idx - PRE; f = j / 10; b = j % 10;
                if (f == 0)   fw[0][9 - b] = dout_a;
                if (f == 1)   fw[1][9 - b] = dout_a;
                if (f == 255) fw[2][9 - b] = dout_a;
                if (f == 256) fw[3][9 - b] = dout_a;
            end
            if (mode == 1) start_a = (idx == 5 || idx == 500);
            if (mode == 3 && idx == 100) start_a = 1'b0;
            @(negedge clk);
            idx++;
        end
        check({name, "_busy_len"}, idx, BLK);
        check({name, "_bit_errs"}, bit_errs, 0);
        check({name, "_done_in_busy"}, done_seen, 0);
        check({name, "_done_first_gap"}, done_a, 1);
        check({name, "_dout_first_gap"}, dout_a, 0);
        check({name, "_addr_first_gap"}, mem_addr_a, 0);
        low_len = 0; done_seen = 0; dout_hi = 0;
        while (busy_a !== 1'b1 && low_len < 30) begin
            if (done_a === 1'b1) done_seen++;
            if (dout_a !== 1'b0) dout_hi++;
            if (mode == 1) start_a = (idx == BLK + 5);
            @(negedge clk);
            idx++;
            low_len++;
        end
        if (mode == 1) start_a = 1'b0;
        check({name, "_done_count"}, done_seen, 1);
        check({name, "_gap_dout"}, dout_hi, 0);
        check({name, "_low_len"}, low_len, (mode == 2) ? GAP + 1 : 30);
    endtask

    initial begin
        int seen_done, seen_busy, bcnt;
        logic [39:0] seq;
        logic [39:0] seq_exp;

        rstn_a = 1'b0; start_a = 1'b0;
        rstn_b = 1'b0; start_b = 1'b0;
        for (int k = 0; k < 1024; k++) mem_a[k] = k[7:0];
        mem_b[0] = 8'hA5; mem_b[1] = 8'h3C; mem_b[2] = 8'h00; mem_b[3] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_dout", dout_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_addr", mem_addr_a, 0);
        rstn_a = 1'b1; rstn_b = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy_a, 0);

        // Counting image with hand-computed frames
        start_a_req("cnt", 1'b0);
        observe_block(0, "cnt");
        check("frame0",   fw[0], 10'b0000000001);
        check("frame1",   fw[1], 10'b0000000101);
        check("frame255", fw[2], 10'b1111111101);
        check("frame256", fw[3], 10'b0000000001);

        // Stray START pulses inside PRE, DATA and GAP
        start_a_req("ign", 1'b0);
        observe_block(1, "ign");

        // Random image, three back-to-back blocks with START held high
        for (int k = 0; k < NB; k++) mem_a[k] = 8'($urandom_range(0, 255));
        mem_a[3] = 8'hFF; mem_a[4] = 8'h00;
        start_a_req("b2b", 1'b1);
        observe_block(2, "b2b_0");
        observe_block(2, "b2b_1");
        observe_block(3, "b2b_2");

        // Reset during frame 100
        start_a_req("rst", 1'b0);
        repeat (PRE + 1000 + 3) @(negedge clk);
        check("rst_mid_busy_before", busy_a, 1);
        rstn_a = 1'b0;
        @(negedge clk);
        rstn_a = 1'b1;
        check("rst_mid_dout", dout_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_addr", mem_addr_a, 0);
        seen_done = 0; seen_busy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_a !== 1'b0) seen_done++;
            if (busy_a !== 1'b0) seen_busy++;
        end
        check("rst_mid_no_done", seen_done, 0);
        check("rst_mid_no_busy", seen_busy, 0);
        start_a_req("after_rst", 1'b0);
        observe_block(0, "after_rst");

        // Two-byte instance: exact line sequence, DONE and MEM_ADDR timing
        seq_exp = 40'b1111111111_1010010101_0011110001_0000000000;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        seen_done = 0; bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            seq[39 - i] = dout_b;
            if (busy_b === 1'b1) bcnt++;
            if (done_b === 1'b1) seen_done++;
            if (i == 5)  check("small_addr_pre", mem_addr_b, 0);
            if (i == 11) check("small_addr_f0", mem_addr_b, 1);
            if (i == 25) check("small_addr_f1", mem_addr_b, 1);
            if (i == 30) begin
                check("small_addr_gap", mem_addr_b, 0);
                check("small_done_at_gap", done_b, 1);
            end
            @(negedge clk);
        end
        check("small_seq", seq, seq_exp);
        check("small_busy_len", bcnt, 30);
        check("small_done_count", seen_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmitter for the framed serial link whose receiver hunts for a preamble of ten 1s and then captures fixed-length frames into a 10-bit-addressed buffer.
- On a START request, the block reads NBYTES bytes from a synchronous-read memory.
- It serialises them on DOUT, one bit per CLK_30MHZ rising edge: preamble first, then frames of [8 data bits MSB-first, '0', '1'].
- It sits on the source side of the link, facing the receiver that samples on the falling edge of the same clock.

Parameters:
- NBYTES, 721: frames per block. Byte indices sent are 0..NBYTES-1.
- PRE_LEN, 10: number of preamble '1' bits. Minimum 10.
- GAP_LEN, 10: number of forced-low idle cycles after a block before START is accepted again. Minimum 10.
- AW, 10: memory address width. Must satisfy 2^AW >= NBYTES.

Ports:
- CLK_30MHZ, input, 1: bit clock. All state updates on the rising edge.
- RSTN, input, 1: reset, synchronous, active-low.
- START, input, 1: block request. Sampled only in IDLE.
- MEM_ADDR, output, AW: registered byte address to the source memory.
- MEM_DATA, input, 8: memory read data, valid within 1 cycle of MEM_ADDR.
- DOUT, output, 1: registered serial line. Idle level 0.
- BUSY, output, 1: high while preamble or frames are on DOUT.
- DONE, output, 1: one-cycle pulse at block completion.

Behaviour:
- Reset (RSTN low at a rising edge):
  - Outputs: DOUT=0, BUSY=0, DONE=0, MEM_ADDR=0.
  - Internal: state=IDLE, all counters cleared.
  - Reset overrides everything, including mid-block; the partial block is abandoned and DOUT drops to 0 on the next cycle.
- States: IDLE, PRE, DATA, STOP0, STOP1, GAP.
- IDLE:
  - DOUT=0, BUSY=0, MEM_ADDR=0.
  - START=1 sampled at edge t moves to PRE. DOUT=1 and BUSY=1 from t+1.
- PRE:
  - DOUT=1 for exactly PRE_LEN cycles; MEM_ADDR held at 0.
  - On the last PRE cycle, shift register <= MEM_DATA (byte 0). Next state is DATA.
- DATA:
  - 8 cycles, DOUT = shreg[7] then shreg shifted left (MSB first).
  - On the first DATA cycle of frame k, MEM_ADDR <= k+1. This is not done if k = NBYTES-1; MEM_ADDR then holds.
- STOP0: 1 cycle, DOUT=0.
- STOP1: 1 cycle, DOUT=1.
  - If byte count < NBYTES-1: load shreg <= MEM_DATA, increment byte count, go to DATA.
  - Else: go to GAP.
- Frame length and block length:
  - Each frame is exactly 10 cycles, with no inter-frame gap.
  - Total BUSY duration = PRE_LEN + 10*NBYTES cycles.
- GAP:
  - DOUT=0, BUSY=0, MEM_ADDR=0.
  - DONE=1 on the first GAP cycle only.
  - Stays in GAP for GAP_LEN cycles, then goes to IDLE. START is ignored throughout GAP.
- START handling:
  - START is ignored in every state except IDLE; there is no queuing.
  - START held high continuously produces back-to-back blocks separated by exactly GAP_LEN+1 low cycles: GAP_LEN cycles, plus the IDLE cycle in which START is sampled.
- MEM_DATA is sampled only at shreg-load edges. A memory with 1-cycle read latency is sufficient, since MEM_ADDR leads each load by 9 cycles.
- Counters:
  - Bit counter: 4 bits. Byte counter: AW bits. Gap/preamble counter: 4 bits, with a wider counter if PRE_LEN or GAP_LEN > 15.
  - No counter wraps within a block.
- Data values:
  - Data values 0xFF and 0x00 are transmitted unmodified; no stuffing is applied.
  - The receiver's alignment relies on the 0/1 stop pair and bit counting, not on data content.

Test Plan:
- Reset then START pulse, NBYTES=721, memory[k]=k[7:0]:
  - DOUT=1 for 10 cycles.
  - Then frame 0 = 00000000 01, frame 1 = 00000001 01, frame 255 = 11111111 01, frame 256 = 00000000 01.
  - BUSY high for 7220 cycles, then DONE pulses once and DOUT=0.
- Loopback into the link receiver with a random 721-byte image: receiver buffer contents equal the memory image byte-for-byte and the receiver returns to hunt state; repeat 3 back-to-back blocks with START held high.
- START pulses at cycles 5, 500 and 7225 of a block (inside PRE, DATA and GAP respectively): all ignored. Exactly one block is sent; next START in IDLE starts a new one.
- NBYTES=2, memory = {0xA5, 0x3C}:
  - DOUT sequence = 1111111111 10100101 01 00111100 01 0000000000.
  - DONE coincides with the first trailing 0.
  - MEM_ADDR sequence 0, 1, then 0 in GAP.
- RSTN low for 1 cycle during frame 100:
  - Next cycle DOUT=0, BUSY=0, MEM_ADDR=0, DONE never asserted.
  - A subsequent START produces a complete, correct block beginning at byte 0.
